dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Shares the single data-memory port between two requesters: the pipeline memory stage (CPU) and an external master (debug loader / DMA).
- Fixed priority to the CPU, with a starvation counter that forces one external slot after a bounded wait.
- Routes registered read data back to the owning requester.
- Raises a stall toward the hazard unit whenever the CPU request loses arbitration.

Parameters:
- XLEN, 32, data/address width; byte enables are XLEN/8 wide.
- STARVE_LIMIT, 4, consecutive cycles an external request may be denied before it is forced through; legal range 1..15.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- cpu_req  in  1  CPU access request, held until granted
- cpu_we  in  1  CPU write (1) / read (0)
- cpu_addr  in  XLEN  CPU byte address
- cpu_be  in  XLEN/8  CPU byte enables (writes)
- cpu_wd  in  XLEN  CPU write data
- cpu_gnt  out  1  CPU request accepted this cycle
- cpu_rvalid  out  1  CPU read data valid
- cpu_rd  out  XLEN  CPU read data
- ext_req, ext_we, ext_addr, ext_be, ext_wd  in  1/1/XLEN/XLEN/8/XLEN  external request, same meaning as the CPU set
- ext_gnt  out  1  external request accepted
- ext_rvalid  out  1  external read data valid
- ext_rd  out  XLEN  external read data
- mem_we  out  1  memory write enable
- mem_be  out  XLEN/8  memory byte enables
- mem_addr  out  XLEN  memory address
- mem_wd  out  XLEN  memory write data
- mem_rd  in  XLEN  memory read data; valid one cycle after the address is presented
- stall_cpu  out  1  to hazard unit: cpu_req & ~cpu_gnt

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-high, port reset.
- Reset values:
  - state = CPU_PRI, starve_cnt = 0, resp_valid = 0, resp_owner = CPU.
  - All gnt/rvalid outputs = 0; mem_we = 0; cpu_rd and ext_rd = 0.
  - A read granted in the cycle before reset asserts produces no rvalid.
- State machine, 2 states:
  - CPU_PRI: cpu_req wins. ext is granted only when cpu_req = 0.
  - EXT_PRI: ext_req wins. cpu is granted only when ext_req = 0.
- Grants: combinational from req and state, at most one per cycle. A requester holds req/we/addr/be/wd stable until gnt.
- Memory mux:
  - mem_* is driven combinationally from the granted requester.
  - With no grant: mem_we = 0, mem_be = 0, mem_addr and mem_wd hold the CPU inputs.
  - A write performs in the grant cycle.
- Starvation counter:
  - Increments each cycle ext_req = 1 and ext_gnt = 0, saturating at STARVE_LIMIT.
  - Clears on ext_gnt or when ext_req = 0.
  - When the next value equals STARVE_LIMIT, state goes to EXT_PRI for the following cycle.
  - On ext_gnt in EXT_PRI, state returns to CPU_PRI and the counter clears.
  - Worst-case external latency: STARVE_LIMIT+1 cycles from req to gnt.
  - In EXT_PRI with ext_req dropped: cpu is granted and state returns to CPU_PRI.
- Read response:
  - On a read grant, register resp_valid = 1 and resp_owner = the granted requester.
  - Next cycle the owner's rvalid = 1 and its rd = mem_rd; the other rd holds its last value.
  - Writes produce no rvalid.
  - Back-to-back reads give one rvalid per cycle, and ownership may alternate cycle to cycle.
- Simultaneous events:
  - Same-cycle cpu_req and ext_req: resolved by state.
  - A counter threshold reached in the same cycle as ext_gnt (CPU idle): the counter clears and state stays CPU_PRI.
- stall_cpu: purely combinational, = cpu_req & ~cpu_gnt. It is 1 during any forced EXT slot.
- Latency: grant 0 cycles when uncontested; read data 1 cycle after grant.

Test Plan:
- Reset mid-read: CPU read granted at addr 0x10, reset asserted before the next edge -> no cpu_rvalid, all outputs 0, state CPU_PRI.
- Uncontested CPU access: CPU write 0xDEADBEEF, be = 4'b1111 to 0x20, then read 0x20 -> cpu_gnt same cycle both times, cpu_rvalid one cycle after the read grant with cpu_rd = 0xDEADBEEF, stall_cpu = 0 throughout.
- Uncontested external access: ext write 0x000000AB, be = 4'b0001 to 0x24, then ext read 0x24 -> ext_gnt immediate, ext_rvalid next cycle with ext_rd[7:0] = 0xAB; CPU rvalid stays 0.
- Contention, STARVE_LIMIT = 4: cpu_req and ext_req held high continuously -> CPU granted for 4 cycles, ext granted on cycle 5 with stall_cpu = 1 in that cycle, then CPU again; this pattern repeats every 5 cycles.
- Alternating reads: CPU read 0x30 (holds 0x11111111) and ext read 0x34 (holds 0x22222222) granted on consecutive cycles -> cpu_rvalid then ext_rvalid on consecutive cycles with the correct data; no cross-routing.
- Ext request withdrawn during EXT_PRI: ext_req drops in that cycle -> cpu granted that cycle, state returns to CPU_PRI, starve_cnt = 0.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Arbitrates the single data-memory port between the CPU memory stage and an external master.
// Latency: grant is combinational (0 cycles uncontested); read data returns 1 cycle after grant.
// Backpressure: a requester holds its request until granted; the CPU sees stall_cpu while denied.
module dmem_arbiter #(
  parameter int XLEN         = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [XLEN-1:0]   cpu_addr,
  input  logic [XLEN/8-1:0] cpu_be,
  input  logic [XLEN-1:0]   cpu_wd,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [XLEN-1:0]   cpu_rd,
  input  logic              ext_req,
  input  logic              ext_we,
  input  logic [XLEN-1:0]   ext_addr,
  input  logic [XLEN/8-1:0] ext_be,
  input  logic [XLEN-1:0]   ext_wd,
  output logic              ext_gnt,
  output logic              ext_rvalid,
  output logic [XLEN-1:0]   ext_rd,
  output logic              mem_we,
  output logic [XLEN/8-1:0] mem_be,
  output logic [XLEN-1:0]   mem_addr,
  output logic [XLEN-1:0]   mem_wd,
  input  logic [XLEN-1:0]   mem_rd,
  output logic              stall_cpu
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  typedef enum logic {CPU_PRI = 1'b0, EXT_PRI = 1'b1} state_t;

  state_t          state, state_nxt;
  logic [3:0]      starve_cnt, starve_nxt;
  logic            resp_valid;
  logic            resp_owner;  // 0 = CPU, 1 = external
  logic [XLEN-1:0] cpu_rd_q, ext_rd_q;

  always_comb begin
    cpu_gnt = 1'b0;
    ext_gnt = 1'b0;
    if (state == CPU_PRI) begin
      cpu_gnt = cpu_req;
      ext_gnt = ext_req & ~cpu_req;
    end else begin
      ext_gnt = ext_req;
      cpu_gnt = cpu_req & ~ext_req;
    end
  end

  // Count denied cycles; the threshold flips priority for exactly one slot.
  always_comb begin
    starve_nxt = 4'd0;
    if (ext_req && !ext_gnt)
      starve_nxt = (starve_cnt == LIMIT) ? LIMIT : starve_cnt + 4'd1;

    state_nxt = state;
    if (ext_gnt)
      state_nxt = CPU_PRI;
    else if (state == EXT_PRI && !ext_req)
      state_nxt = CPU_PRI;
    else if (starve_nxt == LIMIT)
      state_nxt = EXT_PRI;
  end

  always_comb begin
    if (ext_gnt) begin
      mem_we   = ext_we;
      mem_be   = ext_be;
      mem_addr = ext_addr;
      mem_wd   = ext_wd;
    end else begin
      mem_we   = cpu_gnt & cpu_we;
      mem_be   = cpu_gnt ? cpu_be : '0;
      mem_addr = cpu_addr;
      mem_wd   = cpu_wd;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= CPU_PRI;
      starve_cnt <= 4'd0;
      resp_valid <= 1'b0;
      resp_owner <= 1'b0;
      cpu_rd_q   <= '0;
      ext_rd_q   <= '0;
    end else begin
      state      <= state_nxt;
      starve_cnt <= starve_nxt;
      resp_valid <= (cpu_gnt & ~cpu_we) | (ext_gnt & ~ext_we);
      resp_owner <= ext_gnt;
      if (cpu_rvalid) cpu_rd_q <= mem_rd;
      if (ext_rvalid) ext_rd_q <= mem_rd;
    end
  end

  // Memory read data arrives in the response cycle; the idle side keeps its last word.
  assign cpu_rvalid = resp_valid & ~resp_owner;
  assign ext_rvalid = resp_valid & resp_owner;
  assign cpu_rd     = cpu_rvalid ? mem_rd : cpu_rd_q;
  assign ext_rd     = ext_rvalid ? mem_rd : ext_rd_q;
  assign stall_cpu  = cpu_req & ~cpu_gnt;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a one-cycle-latency memory model.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_req, cpu_we, ext_req, ext_we;
  logic [31:0] cpu_addr, cpu_wd, ext_addr, ext_wd;
  logic [3:0]  cpu_be, ext_be;
  logic        cpu_gnt, cpu_rvalid, ext_gnt, ext_rvalid;
  logic [31:0] cpu_rd, ext_rd;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr, mem_wd, mem_rd;
  logic        stall_cpu;

  int errors = 0;
  int checks = 0;

  logic [31:0] mem [0:63];

  always #5 clk = ~clk;

  dmem_arbiter #(.XLEN(32), .STARVE_LIMIT(4)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_be(cpu_be), .cpu_wd(cpu_wd),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rd(cpu_rd),
    .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr), .ext_be(ext_be), .ext_wd(ext_wd),
    .ext_gnt(ext_gnt), .ext_rvalid(ext_rvalid), .ext_rd(ext_rd),
    .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr), .mem_wd(mem_wd), .mem_rd(mem_rd),
    .stall_cpu(stall_cpu)
  );

  always @(posedge clk) begin
    if (mem_we)
      for (int b = 0; b < 4; b++)
        if (mem_be[b]) mem[mem_addr[7:2]][8*b +: 8] <= mem_wd[8*b +: 8];
    mem_rd <= mem[mem_addr[7:2]];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cpu_drive(input logic req, input logic we, input logic [31:0] addr,
                           input logic [3:0] be, input logic [31:0] wd);
    cpu_req = req; cpu_we = we; cpu_addr = addr; cpu_be = be; cpu_wd = wd;
  endtask

  task automatic ext_drive(input logic req, input logic we, input logic [31:0] addr,
                           input logic [3:0] be, input logic [31:0] wd);
    ext_req = req; ext_we = we; ext_addr = addr; ext_be = be; ext_wd = wd;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    mem[12] = 32'h11111111;  // 0x30
    mem[13] = 32'h22222222;  // 0x34
    reset = 1'b1;
    cpu_drive(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    ext_drive(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    tick(); tick();
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_cpu_gnt", {31'b0, cpu_gnt}, 32'd0);
    chk("rst_ext_gnt", {31'b0, ext_gnt}, 32'd0);
    chk("rst_cpu_rvalid", {31'b0, cpu_rvalid}, 32'd0);
    chk("rst_ext_rvalid", {31'b0, ext_rvalid}, 32'd0);
    chk("rst_mem_we", {31'b0, mem_we}, 32'd0);
    chk("rst_cpu_rd", cpu_rd, 32'd0);
    chk("rst_ext_rd", ext_rd, 32'd0);
    chk("rst_starve", {28'b0, dut.starve_cnt}, 32'd0);
    chk("rst_state", {31'b0, dut.state}, 32'd0);

    // Read granted, then reset lands before the response edge
    @(negedge clk);
    cpu_drive(1'b1, 1'b0, 32'h10, 4'hF, 32'h0);
    #1;
    chk("midrd_gnt", {31'b0, cpu_gnt}, 32'd1);
    #2;
    reset = 1'b1;
    cpu_drive(1'b0, 1'b0, 32'h10, 4'hF, 32'h0);
    tick();
    chk("midrd_rvalid", {31'b0, cpu_rvalid}, 32'd0);
    chk("midrd_cpu_rd", cpu_rd, 32'd0);
    chk("midrd_state", {31'b0, dut.state}, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Uncontested CPU write then read
    @(negedge clk);
    cpu_drive(1'b1, 1'b1, 32'h20, 4'hF, 32'hDEADBEEF);
    #1;
    chk("cpu_wr_gnt", {31'b0, cpu_gnt}, 32'd1);
    chk("cpu_wr_stall", {31'b0, stall_cpu}, 32'd0);
    chk("cpu_wr_mem_we", {31'b0, mem_we}, 32'd1);
    chk("cpu_wr_mem_addr", mem_addr, 32'h20);
    tick();
    chk("cpu_wr_no_rvalid", {31'b0, cpu_rvalid}, 32'd0);
    @(negedge clk);
    cpu_drive(1'b1, 1'b0, 32'h20, 4'hF, 32'h0);
    #1;
    chk("cpu_rd_gnt", {31'b0, cpu_gnt}, 32'd1);
    chk("cpu_rd_mem_we", {31'b0, mem_we}, 32'd0);
    chk("cpu_rd_stall", {31'b0, stall_cpu}, 32'd0);
    tick();
    chk("cpu_rd_rvalid", {31'b0, cpu_rvalid}, 32'd1);
    chk("cpu_rd_data", cpu_rd, 32'hDEADBEEF);
    chk("cpu_rd_ext_rvalid", {31'b0, ext_rvalid}, 32'd0);
    @(negedge clk);
    cpu_drive(1'b0, 1'b0, 32'h20, 4'h0, 32'h0);
    #1;
    chk("idle_mem_be", {28'b0, mem_be}, 32'd0);
    tick();
    chk("cpu_rd_hold_rvalid", {31'b0, cpu_rvalid}, 32'd0);
    chk("cpu_rd_hold_data", cpu_rd, 32'hDEADBEEF);

    // Uncontested external byte write then read
    @(negedge clk);
    ext_drive(1'b1, 1'b1, 32'h24, 4'b0001, 32'h000000AB);
    #1;
    chk("ext_wr_gnt", {31'b0, ext_gnt}, 32'd1);
    chk("ext_wr_mem_be", {28'b0, mem_be}, 32'h1);
    chk("ext_wr_mem_addr", mem_addr, 32'h24);
    tick();
    chk("ext_wr_no_rvalid", {31'b0, ext_rvalid}, 32'd0);
    @(negedge clk);
    ext_drive(1'b1, 1'b0, 32'h24, 4'hF, 32'h0);
    #1;
    chk("ext_rd_gnt", {31'b0, ext_gnt}, 32'd1);
    tick();
    chk("ext_rd_rvalid", {31'b0, ext_rvalid}, 32'd1);
    chk("ext_rd_data", ext_rd, 32'h000000AB);
    chk("ext_rd_cpu_rvalid", {31'b0, cpu_rvalid}, 32'd0);
    chk("ext_rd_cpu_rd_hold", cpu_rd, 32'hDEADBEEF);
    @(negedge clk);
    ext_drive(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    tick();

    // Continuous contention: 4 CPU slots then one forced external slot, twice
    @(negedge clk);
    cpu_drive(1'b1, 1'b0, 32'h30, 4'hF, 32'h0);
    ext_drive(1'b1, 1'b0, 32'h34, 4'hF, 32'h0);
    for (int k = 1; k <= 10; k++) begin
      #1;
      chk($sformatf("cont%0d_cpu_gnt", k), {31'b0, cpu_gnt}, (k % 5 != 0) ? 32'd1 : 32'd0);
      chk($sformatf("cont%0d_ext_gnt", k), {31'b0, ext_gnt}, (k % 5 == 0) ? 32'd1 : 32'd0);
      chk($sformatf("cont%0d_stall", k), {31'b0, stall_cpu}, (k % 5 == 0) ? 32'd1 : 32'd0);
      tick();
      if (k % 5 == 0) begin
        chk($sformatf("cont%0d_ext_rvalid", k), {31'b0, ext_rvalid}, 32'd1);
        chk($sformatf("cont%0d_cpu_rvalid", k), {31'b0, cpu_rvalid}, 32'd0);
        chk($sformatf("cont%0d_ext_rd", k), ext_rd, 32'h22222222);
      end else begin
        chk($sformatf("cont%0d_cpu_rvalid", k), {31'b0, cpu_rvalid}, 32'd1);
        chk($sformatf("cont%0d_ext_rvalid", k), {31'b0, ext_rvalid}, 32'd0);
        chk($sformatf("cont%0d_cpu_rd", k), cpu_rd, 32'h11111111);
      end
      @(negedge clk);
    end
    cpu_drive(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    ext_drive(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    tick();

    // Reach the forced slot, then withdraw the external request inside it
    @(negedge clk);
    cpu_drive(1'b1, 1'b0, 32'h30, 4'hF, 32'h0);
    ext_drive(1'b1, 1'b0, 32'h34, 4'hF, 32'h0);
    for (int k = 1; k <= 4; k++) begin
      tick();
      @(negedge clk);
    end
    #1;
    chk("wd_state_ext_pri", {31'b0, dut.state}, 32'd1);
    chk("wd_starve_sat", {28'b0, dut.starve_cnt}, 32'd4);
    ext_drive(1'b0, 1'b0, 32'h34, 4'hF, 32'h0);
    #1;
    chk("wd_cpu_gnt", {31'b0, cpu_gnt}, 32'd1);
    chk("wd_ext_gnt", {31'b0, ext_gnt}, 32'd0);
    chk("wd_stall", {31'b0, stall_cpu}, 32'd0);
    tick();
    chk("wd_state_back", {31'b0, dut.state}, 32'd0);
    chk("wd_starve_clr", {28'b0, dut.starve_cnt}, 32'd0);
    @(negedge clk);
    ext_drive(1'b1, 1'b0, 32'h34, 4'hF, 32'h0);
    #1;
    chk("wd_cpu_wins_again", {31'b0, cpu_gnt}, 32'd1);
    chk("wd_ext_denied", {31'b0, ext_gnt}, 32'd0);
    cpu_drive(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    ext_drive(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
